// File: rtl/ghost_motion_executor.sv
// Per-ghost motion executor: turns the one-hot direction from ghost_control into
// pixel steps on the tile grid, with start delay, freeze, respawn and tunnel wrap.
module ghost_motion_executor #(
    parameter logic [10:0] HOME_X      = 11'd320,
    parameter logic [9:0]  HOME_Y      = 10'd240,
    parameter int unsigned TILE        = 16,
    parameter int unsigned STEP        = 2,
    parameter int unsigned START_DELAY = 60,
    parameter logic [10:0] X_MIN       = 11'd0,
    parameter logic [10:0] X_MAX       = 11'd624
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        step_en,
    input  logic [3:0]  move_direction,
    input  logic [3:0]  valid_moves,
    input  logic        freeze,
    input  logic        respawn,
    output logic [10:0] ghost_pos_x,
    output logic [9:0]  ghost_pos_y,
    output logic [3:0]  prev_direction,
    output logic        moving,
    output logic        tile_done
);

    localparam int unsigned StepsPerTile = TILE / STEP;
    localparam int unsigned StepW        = $clog2(StepsPerTile) + 1;
    localparam int unsigned DelayW       = $clog2(START_DELAY) + 1;
    localparam logic [10:0] StepX        = 11'(STEP);
    localparam logic [9:0]  StepY        = 10'(STEP);
    localparam logic [3:0]  DirRight     = 4'b0001;
    localparam logic [3:0]  DirUp        = 4'b0010;
    localparam logic [3:0]  DirDown      = 4'b0100;
    localparam logic [3:0]  DirLeft      = 4'b1000;

    typedef enum logic [1:0] {StHome, StAligned, StMoving} state_e;

    state_e              state_q, state_d;
    logic [10:0]         pos_x_q, pos_x_d, step_x;
    logic [9:0]          pos_y_q, pos_y_d, step_y;
    logic [3:0]          prev_q, prev_d, step_dir;
    logic [StepW-1:0]    step_cnt_q, step_cnt_d;
    logic [DelayW-1:0]   delay_cnt_q, delay_cnt_d;
    logic                tile_done_q, tile_done_d;
    logic                legal;

    assign legal = $onehot(move_direction) && (|(move_direction & valid_moves));

    // In ALIGNED the candidate move comes from the input; mid-tile it is locked to prev.
    assign step_dir = (state_q == StAligned) ? move_direction : prev_q;

    always_comb begin
        step_x = pos_x_q;
        step_y = pos_y_q;
        case (step_dir)
            DirRight: step_x = pos_x_q + StepX;
            DirLeft:  step_x = pos_x_q - StepX;
            DirDown:  step_y = pos_y_q + StepY;
            DirUp:    step_y = pos_y_q - StepY;
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        prev_d      = prev_q;
        step_cnt_d  = step_cnt_q;
        delay_cnt_d = delay_cnt_q;
        tile_done_d = 1'b0;

        if (!freeze && step_en) begin
            unique case (state_q)
                StHome: begin
                    if (delay_cnt_q == DelayW'(START_DELAY - 1)) begin
                        delay_cnt_d = '0;
                        state_d     = StAligned;
                    end else begin
                        delay_cnt_d = delay_cnt_q + 1'b1;
                    end
                end
                StAligned: begin
                    if (legal) begin
                        prev_d = move_direction;
                        if (move_direction == DirLeft && pos_x_q == X_MIN) begin
                            pos_x_d     = X_MAX;
                            tile_done_d = 1'b1;
                        end else if (move_direction == DirRight && pos_x_q == X_MAX) begin
                            pos_x_d     = X_MIN;
                            tile_done_d = 1'b1;
                        end else begin
                            pos_x_d    = step_x;
                            pos_y_d    = step_y;
                            step_cnt_d = StepW'(1);
                            state_d    = StMoving;
                        end
                    end
                end
                StMoving: begin
                    pos_x_d = step_x;
                    pos_y_d = step_y;
                    if (step_cnt_q == StepW'(StepsPerTile - 1)) begin
                        step_cnt_d  = '0;
                        tile_done_d = 1'b1;
                        state_d     = StAligned;
                    end else begin
                        step_cnt_d = step_cnt_q + 1'b1;
                    end
                end
                default: state_d = StHome;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || respawn) begin
            state_q     <= StHome;
            pos_x_q     <= HOME_X;
            pos_y_q     <= HOME_Y;
            prev_q      <= 4'b0000;
            step_cnt_q  <= '0;
            delay_cnt_q <= '0;
            tile_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            prev_q      <= prev_d;
            step_cnt_q  <= step_cnt_d;
            delay_cnt_q <= delay_cnt_d;
            tile_done_q <= tile_done_d;
        end
    end

    assign ghost_pos_x    = pos_x_q;
    assign ghost_pos_y    = pos_y_q;
    assign prev_direction = prev_q;
    assign moving         = (state_q == StMoving);
    assign tile_done      = tile_done_q;

endmodule

// File: tb/tb_ghost_motion_executor.sv
// Directed plus randomized bench for ghost_motion_executor against a pixel-level
// reference model (tracks pixels left in the tile rather than step counts).
module tb_ghost_motion_executor;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        step_en = 1'b0;
    logic [3:0]  move_direction = 4'b0000;
    logic [3:0]  valid_moves = 4'b0000;
    logic        freeze = 1'b0;
    logic        respawn = 1'b0;
    logic [10:0] ghost_pos_x;
    logic [9:0]  ghost_pos_y;
    logic [3:0]  prev_direction;
    logic        moving;
    logic        tile_done;

    int checks = 0;
    int failures = 0;

    localparam int MHome = 0, MAligned = 1, MMoving = 2;
    localparam logic [3:0] R = 4'b0001, U = 4'b0010, D = 4'b0100, L = 4'b1000;

    logic [10:0] m_x;
    logic [9:0]  m_y;
    logic [3:0]  m_prev;
    int          m_mode, m_home_left, m_remain;
    logic        m_td;

    ghost_motion_executor dut (
        .clk            (clk),
        .reset          (reset),
        .step_en        (step_en),
        .move_direction (move_direction),
        .valid_moves    (valid_moves),
        .freeze         (freeze),
        .respawn        (respawn),
        .ghost_pos_x    (ghost_pos_x),
        .ghost_pos_y    (ghost_pos_y),
        .prev_direction (prev_direction),
        .moving         (moving),
        .tile_done      (tile_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_home();
        m_x = 11'd320; m_y = 10'd240; m_prev = 4'b0000;
        m_mode = MHome; m_home_left = 60; m_remain = 0; m_td = 1'b0;
    endtask

    task automatic model_move(input logic [3:0] dir);
        case (dir)
            R: m_x = m_x + 11'd2;
            L: m_x = m_x - 11'd2;
            D: m_y = m_y + 10'd2;
            U: m_y = m_y - 10'd2;
            default: ;
        endcase
    endtask

    task automatic model_cycle(input logic se, input logic [3:0] dir, input logic [3:0] vld,
                               input logic frz, input logic rsp, input logic rst);
        if (rst || rsp) begin
            model_home();
        end else begin
            m_td = 1'b0;
            if (!frz && se) begin
                if (m_mode == MHome) begin
                    m_home_left--;
                    if (m_home_left == 0) m_mode = MAligned;
                end else if (m_mode == MAligned) begin
                    if ($countones(dir) == 1 && (dir & vld) != 4'b0000) begin
                        m_prev = dir;
                        if (dir == L && m_x == 11'd0) begin
                            m_x = 11'd624; m_td = 1'b1;
                        end else if (dir == R && m_x == 11'd624) begin
                            m_x = 11'd0; m_td = 1'b1;
                        end else begin
                            model_move(dir);
                            m_remain = 16 - 2;
                            m_mode = MMoving;
                        end
                    end
                end else begin
                    model_move(m_prev);
                    m_remain -= 2;
                    if (m_remain == 0) begin
                        m_mode = MAligned; m_td = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic tick(input logic se, input logic [3:0] dir, input logic [3:0] vld,
                        input logic frz = 1'b0, input logic rsp = 1'b0, input logic rst = 1'b0);
        step_en = se; move_direction = dir; valid_moves = vld;
        freeze = frz; respawn = rsp; reset = rst;
        @(posedge clk);
        model_cycle(se, dir, vld, frz, rsp, rst);
        #1;
        check("pos_x", 32'(ghost_pos_x), 32'(m_x));
        check("pos_y", 32'(ghost_pos_y), 32'(m_y));
        check("prev_direction", 32'(prev_direction), 32'(m_prev));
        check("moving", 32'(moving), 32'(m_mode == MMoving));
        check("tile_done", 32'(tile_done), 32'(m_td));
    endtask

    initial begin
        logic [3:0] rd, rv;
        int td_count;
        model_home();

        // Reset and start delay: 59 ticks stay home, 60th leaves home without moving.
        tick(1'b0, R, 4'hF, 1'b0, 1'b0, 1'b1);
        check("reset_x", 32'(ghost_pos_x), 32'd320);
        check("reset_y", 32'(ghost_pos_y), 32'd240);
        check("reset_prev", 32'(prev_direction), 32'd0);
        for (int i = 0; i < 59; i++) begin
            tick(1'b1, R, 4'hF);
            tick(1'b0, R, 4'hF);
        end
        check("home_59_x", 32'(ghost_pos_x), 32'd320);
        check("home_59_moving", 32'(moving), 32'd0);
        tick(1'b1, R, 4'hF);
        check("home_60_x", 32'(ghost_pos_x), 32'd320);

        // One tile right.
        td_count = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, R, 4'hF);
            if (i < 7) check("t2_moving", 32'(moving), 32'd1);
            td_count += int'(tile_done);
            tick(1'b0, R, 4'hF);
            td_count += int'(tile_done);
        end
        check("t2_x", 32'(ghost_pos_x), 32'd336);
        check("t2_prev", 32'(prev_direction), 32'(R));
        check("t2_tile_done_count", 32'(td_count), 32'd1);

        // Direction change mid-tile is ignored until alignment.
        for (int i = 0; i < 3; i++) tick(1'b1, R, 4'hF);
        for (int i = 0; i < 5; i++) tick(1'b1, U, 4'hF);
        check("t3_x", 32'(ghost_pos_x), 32'd352);
        check("t3_prev", 32'(prev_direction), 32'(R));
        tick(1'b1, U, 4'hF);
        check("t3_up_y", 32'(ghost_pos_y), 32'd238);
        check("t3_up_prev", 32'(prev_direction), 32'(U));
        for (int i = 0; i < 7; i++) tick(1'b1, U, 4'hF);
        check("t3_up_done", 32'(ghost_pos_y), 32'd224);

        // Blocked and multi-hot requests.
        tick(1'b1, D, 4'b1011);
        check("t4_blocked_y", 32'(ghost_pos_y), 32'd224);
        check("t4_blocked_prev", 32'(prev_direction), 32'(U));
        tick(1'b1, 4'b0110, 4'hF);
        check("t4_multihot_moving", 32'(moving), 32'd0);
        tick(1'b1, 4'b0000, 4'hF);

        // Walk left to the tunnel mouth, then wrap both ways.
        for (int i = 0; i < 400 && !(m_x == 11'd0 && m_mode == MAligned); i++) tick(1'b1, L, 4'hF);
        check("t5_at_x0", 32'(ghost_pos_x), 32'd0);
        tick(1'b1, L, 4'hF);
        check("t5_wrap_left_x", 32'(ghost_pos_x), 32'd624);
        check("t5_wrap_left_td", 32'(tile_done), 32'd1);
        check("t5_wrap_left_moving", 32'(moving), 32'd0);
        tick(1'b1, R, 4'hF);
        check("t5_wrap_right_x", 32'(ghost_pos_x), 32'd0);
        check("t5_wrap_right_prev", 32'(prev_direction), 32'(R));

        // Freeze mid-tile, resume, then respawn mid-tile.
        for (int i = 0; i < 3; i++) tick(1'b1, R, 4'hF);
        for (int i = 0; i < 5; i++) tick(1'b1, L, 4'hF, 1'b1);
        check("t6_frozen_x", 32'(ghost_pos_x), 32'd6);
        for (int i = 0; i < 5; i++) tick(1'b1, L, 4'hF);
        check("t6_resume_x", 32'(ghost_pos_x), 32'd16);
        check("t6_resume_td", 32'(tile_done), 32'd1);
        for (int i = 0; i < 2; i++) tick(1'b1, D, 4'hF);
        tick(1'b1, D, 4'hF, 1'b0, 1'b1);
        check("t6_respawn_x", 32'(ghost_pos_x), 32'd320);
        check("t6_respawn_y", 32'(ghost_pos_y), 32'd240);
        check("t6_respawn_prev", 32'(prev_direction), 32'd0);
        for (int i = 0; i < 59; i++) tick(1'b1, D, 4'hF);
        tick(1'b1, D, 4'hF);
        check("t6_delay_restart_y", 32'(ghost_pos_y), 32'd240);
        tick(1'b1, D, 4'hF);
        check("t6_after_delay_y", 32'(ghost_pos_y), 32'd242);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 9) < 8) rd = 4'b0001 << $urandom_range(0, 3);
            else rd = 4'($urandom);
            rv = 4'($urandom);
            if ($urandom_range(0, 1) == 1) rv = rv | rd;
            tick($urandom_range(0, 9) < 6, rd, rv,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 299) == 0,
                 $urandom_range(0, 999) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
